// File: rtl/lbm_field_streamer.sv
// lbm_field_streamer: captures per-cell LBM macroscopic fields, keeps the
// selected ones, packs them densely into AXI4-Stream beats and queues the
// beats in a small FIFO. One frame = DEPTH cells, closed with TLAST.
module lbm_field_streamer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned AXIS_WIDTH = 64,
  parameter int unsigned DEPTH      = 2500,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [3:0]              field_mask,
  input  logic [7:0]              decimate,
  input  logic                    sample_valid,
  input  logic [DATA_WIDTH-1:0]   rho,
  input  logic [DATA_WIDTH-1:0]   u_x,
  input  logic [DATA_WIDTH-1:0]   u_y,
  input  logic [DATA_WIDTH-1:0]   u_squared,
  output logic                    m_axis_tvalid,
  output logic [AXIS_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    overflow,
  output logic [31:0]             frame_count,
  output logic                    busy
);

  localparam int unsigned LANES     = AXIS_WIDTH / DATA_WIDTH;
  localparam int unsigned STRB_W    = AXIS_WIDTH / 8;
  localparam int unsigned LANE_STRB = DATA_WIDTH / 8;
  localparam int unsigned CW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW        = $clog2(2 * LANES);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned NW        = AW + 1;
  localparam int unsigned SPW       = NW + 1;
  localparam int unsigned BW        = AXIS_WIDTH + STRB_W + 1;

  // Frame / packer state
  logic [CW-1:0]         r_cell;
  logic [3:0]            r_mask;
  logic [7:0]            r_dec;
  logic [7:0]            r_d;
  logic [FW-1:0]         r_fill;
  logic [AXIS_WIDTH-1:0] r_lanes;
  logic [31:0]           r_frame_count;
  logic                  r_overflow;
  logic                  r_busy;

  // FIFO state, entry = {tdata, tstrb, tlast}
  logic [BW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [NW-1:0]         r_count;

  logic                    w_cap;
  logic                    w_first;
  logic                    w_last;
  logic                    w_emit;
  logic [3:0]              w_mask;
  logic [3:0]              w_take;
  logic [7:0]              w_dec;
  logic [8:0]              w_d_inc;
  logic [DATA_WIDTH-1:0]   w_field [4];
  logic [FW-1:0]           w_slot [4];
  logic [FW-1:0]           w_pos;
  logic [FW-1:0]           w_over;
  logic [FW-1:0]           w_n0;
  logic [2*AXIS_WIDTH-1:0] w_wide;
  logic                    w_full;
  logic                    w_push0;
  logic                    w_push1;
  logic [STRB_W-1:0]       w_strb0;
  logic [STRB_W-1:0]       w_strb1;
  logic [BW-1:0]           w_beat0;
  logic [BW-1:0]           w_beat1;
  logic                    w_pop;
  logic                    w_acc0;
  logic                    w_acc1;
  logic                    w_drop;
  logic [SPW-1:0]          w_space;
  logic [BW-1:0]           w_head;

  // Cell 0 uses the live mask/decimate; later cells use the latched copies.
  assign w_cap    = en & sample_valid;
  assign w_first  = (r_cell == '0);
  assign w_last   = (r_cell == CW'(DEPTH - 1));
  assign w_mask   = w_first ? field_mask : r_mask;
  assign w_dec    = w_first ? ((decimate == 8'd0) ? 8'd1 : decimate) : r_dec;
  assign w_emit   = (r_d == 8'd0);
  assign w_take   = w_mask & {4{w_cap & w_emit}};
  assign w_d_inc  = {1'b0, r_d} + 9'd1;

  assign w_field[0] = rho;
  assign w_field[1] = u_x;
  assign w_field[2] = u_y;
  assign w_field[3] = u_squared;

  // Lane slot for each selected field, appended in rho/u_x/u_y/u_sq order.
  always_comb begin
    w_pos = r_fill;
    for (int i = 0; i < 4; i++) begin
      w_slot[i] = w_pos;
      if (w_take[i]) w_pos = w_pos + FW'(1);
    end
  end

  // Two-beat-wide staging: current partial beat plus newly appended fields.
  always_comb begin
    w_wide = {{AXIS_WIDTH{1'b0}}, r_lanes};
    for (int j = 0; j < 2 * LANES; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (w_take[i] && (w_slot[i] == FW'(j))) w_wide[j*DATA_WIDTH +: DATA_WIDTH] = w_field[i];
      end
    end
  end

  assign w_full  = (w_pos >= FW'(LANES));
  assign w_over  = w_pos - FW'(LANES);
  assign w_n0    = w_full ? FW'(LANES) : w_pos;
  // A full beat, or the frame's final partial; on the last cell both can occur.
  assign w_push0 = w_cap & w_emit & (w_full | (w_last & (w_pos != '0)));
  assign w_push1 = w_cap & w_emit & w_last & w_full & (w_over != '0);

  // Byte strobes for the filled lanes of each candidate beat.
  always_comb begin
    w_strb0 = '0;
    w_strb1 = '0;
    for (int j = 0; j < LANES; j++) begin
      w_strb0[j*LANE_STRB +: LANE_STRB] = {LANE_STRB{FW'(j) < w_n0}};
      w_strb1[j*LANE_STRB +: LANE_STRB] = {LANE_STRB{FW'(j) < w_over}};
    end
  end

  assign w_beat0 = {w_wide[AXIS_WIDTH-1:0], w_strb0, w_last & ~(w_full & (w_over != '0))};
  assign w_beat1 = {w_wide[2*AXIS_WIDTH-1:AXIS_WIDTH], w_strb1, 1'b1};

  // A same-cycle pop frees a slot for the incoming push.
  assign w_pop   = (r_count != '0) & m_axis_tready;
  assign w_space = SPW'(FIFO_DEPTH) - SPW'(r_count) + SPW'(w_pop);
  assign w_acc0  = w_push0 & (w_space != '0);
  assign w_acc1  = w_push1 & (w_space > SPW'(w_acc0));
  assign w_drop  = (w_push0 & ~w_acc0) | (w_push1 & ~w_acc1);

  // Frame counters, packer, FIFO pointers and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cell        <= '0;
      r_mask        <= '0;
      r_dec         <= 8'd1;
      r_d           <= '0;
      r_fill        <= '0;
      r_lanes       <= '0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
      r_busy        <= 1'b0;
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
    end else begin
      if (w_cap) begin
        if (w_first) begin
          r_mask <= field_mask;
          r_dec  <= w_dec;
        end
        if (w_last) begin
          r_cell        <= '0;
          r_frame_count <= r_frame_count + 32'd1;
          r_d           <= (w_d_inc >= {1'b0, w_dec}) ? 8'd0 : w_d_inc[7:0];
          r_fill        <= '0;
          r_lanes       <= '0;
        end else begin
          r_cell <= r_cell + CW'(1);
          if (w_full) begin
            r_fill  <= w_over;
            r_lanes <= w_wide[2*AXIS_WIDTH-1:AXIS_WIDTH];
          end else begin
            r_fill  <= w_pos;
            r_lanes <= w_wide[AXIS_WIDTH-1:0];
          end
        end
      end
      if (w_drop) r_overflow <= 1'b1;
      r_wr    <= r_wr + AW'(w_acc0) + AW'(w_acc1);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + NW'(w_acc0) + NW'(w_acc1) - NW'(w_pop);
      r_busy  <= (r_fill != '0) | (r_count != '0);
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_acc0) r_mem[r_wr] <= w_beat0;
    if (w_acc1) r_mem[r_wr + AW'(w_acc0)] <= w_beat1;
  end

  assign w_head        = r_mem[r_rd];
  assign m_axis_tvalid = (r_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? w_head[BW-1 -: AXIS_WIDTH] : '0;
  assign m_axis_tstrb  = m_axis_tvalid ? w_head[STRB_W:1] : '0;
  assign m_axis_tlast  = m_axis_tvalid & w_head[0];
  assign overflow      = r_overflow;
  assign frame_count   = r_frame_count;
  assign busy          = r_busy;

endmodule

// File: tb/tb_lbm_field_streamer.sv
// Randomized bench for lbm_field_streamer with a queue-based reference model.
module tb_lbm_field_streamer;

  localparam int unsigned DW    = 16;
  localparam int unsigned AXW   = 64;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned FD    = 4;
  localparam int unsigned LANES = AXW / DW;
  localparam int unsigned SW    = AXW / 8;
  localparam int unsigned BW    = AXW + SW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en, sv, tready;
  logic [3:0]     mask;
  logic [7:0]     dec;
  logic [DW-1:0]  f_rho, f_ux, f_uy, f_usq;
  logic           tvalid, tlast, ovf, busy;
  logic [AXW-1:0] tdata;
  logic [SW-1:0]  tstrb;
  logic [31:0]    fcnt;

  lbm_field_streamer #(
    .DATA_WIDTH(DW), .AXIS_WIDTH(AXW), .DEPTH(DEPTH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .field_mask(mask), .decimate(dec),
    .sample_valid(sv), .rho(f_rho), .u_x(f_ux), .u_y(f_uy), .u_squared(f_usq),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tstrb(tstrb),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .overflow(ovf),
    .frame_count(fcnt), .busy(busy)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view, values queued then chunked into beats.
  logic [DW-1:0] pend[$];
  logic [BW-1:0] q[$];
  int            m_cell, m_d, m_dec;
  logic [3:0]    m_mask;
  bit            m_emit, m_ovf, m_busy, m_rst_seen;
  logic [31:0]   m_fc;

  task automatic model_reset();
    pend.delete();
    q.delete();
    m_cell = 0; m_d = 0; m_dec = 1; m_mask = '0; m_emit = 0;
    m_fc = '0; m_ovf = 0; m_busy = 0;
  endtask

  task automatic emit_beat(input int n, input bit last);
    logic [AXW-1:0] d;
    logic [SW-1:0]  s;
    d = '0;
    s = '0;
    for (int i = 0; i < n; i++) begin
      d[i*DW +: DW] = pend.pop_front();
      s[i*2 +: 2]   = 2'b11;
    end
    if (q.size() < FD) q.push_back({d, s, last});
    else m_ovf = 1;
  endtask

  task automatic model_step();
    logic [DW-1:0] vals [4];
    bit last;
    if (rst) begin
      model_reset();
      m_rst_seen = 1;
      return;
    end
    m_rst_seen = 0;
    m_busy = (pend.size() != 0) || (q.size() != 0);
    if (q.size() != 0 && tready) void'(q.pop_front());
    if (en && sv) begin
      vals[0] = f_rho; vals[1] = f_ux; vals[2] = f_uy; vals[3] = f_usq;
      last = (m_cell == DEPTH - 1);
      if (m_cell == 0) begin
        m_mask = mask;
        m_dec  = (dec == 0) ? 1 : int'(dec);
        m_emit = (m_d == 0);
      end
      if (m_emit) begin
        for (int i = 0; i < 4; i++) if (m_mask[i]) pend.push_back(vals[i]);
        while (pend.size() >= LANES) emit_beat(LANES, last && (pend.size() == LANES));
        if (last && pend.size() > 0) emit_beat(pend.size(), 1'b1);
      end
      if (last) begin
        m_cell = 0;
        m_fc++;
        m_d = (m_d + 1 >= m_dec) ? 0 : m_d + 1;
      end else begin
        m_cell++;
      end
    end
  endtask

  task automatic check_outputs();
    chk_eq("tvalid", 128'(tvalid), 128'(q.size() != 0));
    if (q.size() != 0) chk_eq("beat", 128'({tdata, tstrb, tlast}), 128'(q[0]));
    else if (m_rst_seen) chk_eq("idle_beat", 128'({tdata, tstrb, tlast}), 128'(0));
    chk_eq("overflow", 128'(ovf), 128'(m_ovf));
    chk_eq("frame_count", 128'(fcnt), 128'(m_fc));
    chk_eq("busy", 128'(busy), 128'(m_busy));
  endtask

  // Phases: full mask, partial beats, decimation, backpressure, random mix, random resets.
  initial begin
    rst = 1'b1; en = 1'b0; sv = 1'b0; tready = 1'b0;
    mask = 4'h0; dec = 8'd1;
    f_rho = '0; f_ux = '0; f_uy = '0; f_usq = '0;
    model_reset();
    m_rst_seen = 1;
    repeat (2) @(posedge clk);
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        check_outputs();
        case (ph)
          0: begin mask = 4'hF; dec = 8'd1; tready = 1'b1; sv = 1'b1; en = 1'b1; end
          1: begin
            mask = 4'h7; dec = 8'd1; en = 1'b1;
            tready = ($urandom_range(0, 3) != 0);
            sv     = ($urandom_range(0, 3) != 0);
          end
          2: begin mask = 4'h1; dec = 8'd3; tready = 1'b1; sv = 1'b1; en = 1'b1; end
          3: begin
            mask = 4'hF; dec = 8'd1; en = 1'b1;
            tready = (c >= 120) && ($urandom_range(0, 1) == 1);
            sv     = (c < 60) || ($urandom_range(0, 1) == 1);
          end
          default: begin
            if ($urandom_range(0, 4) == 0) mask = 4'($urandom);
            if ($urandom_range(0, 9) == 0) dec = 8'($urandom_range(0, 3));
            tready = ($urandom_range(0, 2) != 0);
            sv     = ($urandom_range(0, 3) != 0);
            en     = ($urandom_range(0, 7) != 0);
          end
        endcase
        rst   = (c < 2) || (ph == 5 && $urandom_range(0, 40) == 0);
        f_rho = 16'($urandom);
        f_ux  = 16'($urandom);
        f_uy  = 16'($urandom);
        f_usq = 16'($urandom);
        model_step();
      end
    end
    @(negedge clk);
    check_outputs();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
